// File: rtl/rx_ber_checker_if.sv
// Sample-stream and status bundle for rx_ber_checker.
// The master side drives the samples; the slave side (the checker) returns bits, lock and counters.
interface rx_ber_checker_if #(
   parameter int WW_INPUT = 8,
   parameter int OS       = 4,
   parameter int WW_CNT   = 32
);
   localparam int PW = $clog2(OS);

   logic                       i_en;
   logic signed [WW_INPUT-1:0] i_data;
   logic [PW-1:0]              i_phase;
   logic                       i_clr_cnt;
   logic                       o_bit;
   logic                       o_bit_valid;
   logic                       o_lock;
   logic [WW_CNT-1:0]          o_bit_cnt;
   logic [WW_CNT-1:0]          o_err_cnt;

   modport master (
      output i_en, i_data, i_phase, i_clr_cnt,
      input  o_bit, o_bit_valid, o_lock, o_bit_cnt, o_err_cnt
   );

   modport slave (
      input  i_en, i_data, i_phase, i_clr_cnt,
      output o_bit, o_bit_valid, o_lock, o_bit_cnt, o_err_cnt
   );
endinterface

// File: rtl/rx_ber_checker.sv
// Downsamples the oversampled FIR output, slices it to bits and checks them against PRBS9 (x^9+x^5+1).
// Optional macro RX_BER_SAT_EN: bit/error counters saturate at all-ones instead of wrapping.
module rx_ber_checker #(
   parameter int WW_INPUT = 8,
   parameter int OS       = 4,
   parameter int WW_CNT   = 32,
   parameter int LOCK_RUN = 32,
   parameter int WIN_LEN  = 128,
   parameter int LOSS_THR = 16
) (
   input logic              clk,
   input logic              i_srst,
   rx_ber_checker_if.slave  bus
);
   localparam int PW  = $clog2(OS);
   localparam int RW  = $clog2(LOCK_RUN + 1);
   localparam int WLW = $clog2(WIN_LEN + 1);
   localparam int WEW = $clog2(LOSS_THR + 1);

   localparam logic [1:0] ST_FILL   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_LOCK   = 2'd2;

   logic [PW-1:0]     ph_cnt;
   logic              bit_q, bit_vld, lock_q;
   logic [1:0]        state, state_n;
   logic [8:0]        sr, sr_n;
   logic [3:0]        fill_cnt, fill_n;
   logic [RW-1:0]     run_cnt, run_n;
   logic [WLW-1:0]    win_bits, wbits_n;
   logic [WEW-1:0]    win_errs, werrs_n;
   logic [WW_CNT-1:0] bit_cnt, err_cnt;
   logic              bit_inc, err_inc, bit_sat, err_sat;
   logic              sample, expected, mismatch;
   logic              unused_data;

   assign sample      = bus.i_en && (ph_cnt == bus.i_phase);
   assign expected    = sr[8] ^ sr[4];
   assign mismatch    = bit_q != expected;
   assign unused_data = ^bus.i_data[WW_INPUT-2:0];

`ifdef RX_BER_SAT_EN
   assign bit_sat = &bit_cnt;
   assign err_sat = &err_cnt;
`else
   assign bit_sat = 1'b0;
   assign err_sat = 1'b0;
`endif

   // FSM and window bookkeeping step only when a registered bit is presented.
   always_comb begin
      state_n = state;
      sr_n    = sr;
      fill_n  = fill_cnt;
      run_n   = run_cnt;
      wbits_n = win_bits;
      werrs_n = win_errs;
      bit_inc = 1'b0;
      err_inc = 1'b0;
      if (bit_vld) begin
         case (state)
            ST_FILL: begin
               sr_n = {sr[7:0], bit_q};
               if (fill_cnt == 4'd8) begin
                  state_n = ST_SEARCH;
                  fill_n  = '0;
                  run_n   = '0;
               end else begin
                  fill_n = fill_cnt + 4'd1;
               end
            end
            ST_SEARCH: begin
               sr_n = {sr[7:0], bit_q};
               if (mismatch) begin
                  run_n = '0;
               end else if (run_cnt == RW'(LOCK_RUN - 1)) begin
                  // an all-zero register trivially predicts zeros; never lock onto it
                  run_n = '0;
                  if (sr_n != 9'd0) begin
                     state_n = ST_LOCK;
                     wbits_n = '0;
                     werrs_n = '0;
                  end
               end else begin
                  run_n = run_cnt + RW'(1);
               end
            end
            ST_LOCK: begin
               sr_n    = {sr[7:0], expected};
               bit_inc = 1'b1;
               err_inc = mismatch;
               if (mismatch && win_errs == WEW'(LOSS_THR - 1)) begin
                  state_n = ST_FILL;
                  sr_n    = '0;
                  fill_n  = '0;
                  wbits_n = '0;
                  werrs_n = '0;
               end else if (win_bits == WLW'(WIN_LEN - 1)) begin
                  wbits_n = '0;
                  werrs_n = '0;
               end else begin
                  wbits_n = win_bits + WLW'(1);
                  werrs_n = win_errs + WEW'(mismatch);
               end
            end
            default: state_n = ST_FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_srst) begin
         ph_cnt   <= '0;
         bit_q    <= 1'b0;
         bit_vld  <= 1'b0;
         lock_q   <= 1'b0;
         state    <= ST_FILL;
         sr       <= '0;
         fill_cnt <= '0;
         run_cnt  <= '0;
         win_bits <= '0;
         win_errs <= '0;
         bit_cnt  <= '0;
         err_cnt  <= '0;
      end else begin
         if (bus.i_en)
            ph_cnt <= (ph_cnt == PW'(OS - 1)) ? '0 : ph_cnt + PW'(1);
         bit_vld <= sample;
         if (sample)
            bit_q <= ~bus.i_data[WW_INPUT-1];
         state    <= state_n;
         lock_q   <= (state_n == ST_LOCK);
         sr       <= sr_n;
         fill_cnt <= fill_n;
         run_cnt  <= run_n;
         win_bits <= wbits_n;
         win_errs <= werrs_n;
         if (bus.i_clr_cnt) begin
            bit_cnt <= '0;
            err_cnt <= '0;
         end else begin
            if (bit_inc && !bit_sat) bit_cnt <= bit_cnt + WW_CNT'(1);
            if (err_inc && !err_sat) err_cnt <= err_cnt + WW_CNT'(1);
         end
      end
   end

   assign bus.o_bit       = bit_q;
   assign bus.o_bit_valid = bit_vld;
   assign bus.o_lock      = lock_q;
   assign bus.o_bit_cnt   = bit_cnt;
   assign bus.o_err_cnt   = err_cnt;
endmodule

// File: tb/tb_rx_ber_checker.sv
// Directed bench for rx_ber_checker: reset, lock acquisition, isolated and burst errors,
// counter clear, and a narrow-counter instance for wrap/saturate behaviour.
module tb_rx_ber_checker;
   localparam int OS = 4;

   logic clk = 1'b0;
   logic srst, srst2;
   logic [8:0] g;
   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   rx_ber_checker_if #(.WW_INPUT(8), .OS(OS), .WW_CNT(32)) bus ();
   rx_ber_checker_if #(.WW_INPUT(8), .OS(OS), .WW_CNT(4))  bus2 ();

   assign bus2.i_en      = bus.i_en;
   assign bus2.i_data    = bus.i_data;
   assign bus2.i_phase   = bus.i_phase;
   assign bus2.i_clr_cnt = bus.i_clr_cnt;

   rx_ber_checker #(.WW_INPUT(8), .OS(OS), .WW_CNT(32)) dut (
      .clk    (clk),
      .i_srst (srst),
      .bus    (bus)
   );

   rx_ber_checker #(.WW_INPUT(8), .OS(OS), .WW_CNT(4)) dut_n (
      .clk    (clk),
      .i_srst (srst2),
      .bus    (bus2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // one symbol = OS samples of the same level; optionally clear while the strobe is up
   task automatic send_sym(input logic b, input logic clr_on_strobe);
      for (int i = 0; i < OS; i++) begin
         @(negedge clk);
         bus.i_en      = 1'b1;
         bus.i_data    = b ? 8'sd64 : -8'sd64;
         bus.i_clr_cnt = clr_on_strobe && (i == OS - 1);
      end
   endtask

   task automatic send_prbs(input int n, input logic inv, input logic clr);
      logic b;
      for (int k = 0; k < n; k++) begin
         b = g[8] ^ g[4];
         g = {g[7:0], b};
         send_sym(b ^ inv, clr);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      bus.i_en      = 1'b0;
      bus.i_clr_cnt = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      srst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         bus.i_en   = 1'($urandom);
         bus.i_data = 8'($urandom);
      end
   endtask

   initial begin
      srst          = 1'b1;
      srst2         = 1'b1;
      g             = 9'h1FF;
      bus.i_en      = 1'b0;
      bus.i_data    = '0;
      bus.i_phase   = 2'd2;
      bus.i_clr_cnt = 1'b0;

      // reset with random activity on the inputs
      do_reset();
      chk("rst_bit",   64'(bus.o_bit),       64'd0);
      chk("rst_valid", 64'(bus.o_bit_valid), 64'd0);
      chk("rst_lock",  64'(bus.o_lock),      64'd0);
      chk("rst_bcnt",  64'(bus.o_bit_cnt),   64'd0);
      chk("rst_ecnt",  64'(bus.o_err_cnt),   64'd0);
      srst     = 1'b0;
      bus.i_en = 1'b0;

      // all-zero stream must never lock
      for (int k = 0; k < 60; k++) send_sym(1'b0, 1'b0);
      settle();
      chk("zero_nolock", 64'(bus.o_lock), 64'd0);

      do_reset();
      srst     = 1'b0;
      bus.i_en = 1'b0;

      // clean PRBS9: lock on bit 41
      send_prbs(40, 1'b0, 1'b0);
      settle();
      chk("lock_b40", 64'(bus.o_lock), 64'd0);
      send_prbs(1, 1'b0, 1'b0);
      settle();
      chk("lock_b41", 64'(bus.o_lock),    64'd1);
      chk("bcnt_b41", 64'(bus.o_bit_cnt), 64'd0);
      send_prbs(1000, 1'b0, 1'b0);
      settle();
      chk("clean_bcnt", 64'(bus.o_bit_cnt), 64'd1000);
      chk("clean_ecnt", 64'(bus.o_err_cnt), 64'd0);
      chk("clean_lock", 64'(bus.o_lock),    64'd1);

      // five isolated errors, locked bit index 1100,1300,...,1900
      for (int k = 0; k < 5; k++) begin
         send_prbs(100, 1'b0, 1'b0);
         send_prbs(1,   1'b1, 1'b0);
         send_prbs(99,  1'b0, 1'b0);
      end
      settle();
      chk("iso_bcnt", 64'(bus.o_bit_cnt), 64'd2000);
      chk("iso_ecnt", 64'(bus.o_err_cnt), 64'd5);
      chk("iso_lock", 64'(bus.o_lock),    64'd1);

      // 16-error burst inside the window that started at locked bit 1920
      send_prbs(15, 1'b1, 1'b0);
      settle();
      chk("burst15_lock", 64'(bus.o_lock), 64'd1);
      send_prbs(1, 1'b1, 1'b0);
      settle();
      chk("burst16_lock", 64'(bus.o_lock),    64'd0);
      chk("burst_bcnt",   64'(bus.o_bit_cnt), 64'd2016);
      chk("burst_ecnt",   64'(bus.o_err_cnt), 64'd21);
      send_prbs(40, 1'b0, 1'b0);
      settle();
      chk("relock_b40", 64'(bus.o_lock), 64'd0);
      send_prbs(1, 1'b0, 1'b0);
      settle();
      chk("relock_b41",  64'(bus.o_lock),    64'd1);
      chk("relock_bcnt", 64'(bus.o_bit_cnt), 64'd2016);
      chk("relock_ecnt", 64'(bus.o_err_cnt), 64'd21);

      // clear on a locked strobe beats the increment
      send_prbs(1, 1'b0, 1'b1);
      settle();
      chk("clr_bcnt", 64'(bus.o_bit_cnt), 64'd0);
      chk("clr_ecnt", 64'(bus.o_err_cnt), 64'd0);
      send_prbs(1, 1'b0, 1'b0);
      settle();
      chk("clr_resume", 64'(bus.o_bit_cnt), 64'd1);
      send_prbs(1, 1'b1, 1'b0);
      settle();
      chk("clr_err_b", 64'(bus.o_bit_cnt), 64'd2);
      chk("clr_err_e", 64'(bus.o_err_cnt), 64'd1);

      // narrow counter instance released on a symbol boundary
      srst2 = 1'b0;
      send_prbs(41, 1'b0, 1'b0);
      settle();
      chk("n_lock", 64'(bus2.o_lock), 64'd1);
      send_prbs(20, 1'b0, 1'b0);
      settle();
`ifdef RX_BER_SAT_EN
      chk("n_bcnt", 64'(bus2.o_bit_cnt), 64'd15);
`else
      chk("n_bcnt", 64'(bus2.o_bit_cnt), 64'd4);
`endif
      chk("n_ecnt",    64'(bus2.o_err_cnt), 64'd0);
      chk("wide_bcnt", 64'(bus.o_bit_cnt),  64'd63);

      // mid-operation reset with i_en high
      @(negedge clk);
      srst       = 1'b1;
      bus.i_en   = 1'b1;
      bus.i_data = 8'sd64;
      @(negedge clk);
      srst     = 1'b0;
      bus.i_en = 1'b0;
      chk("mrst_lock",  64'(bus.o_lock),      64'd0);
      chk("mrst_bcnt",  64'(bus.o_bit_cnt),   64'd0);
      chk("mrst_ecnt",  64'(bus.o_err_cnt),   64'd0);
      chk("mrst_valid", 64'(bus.o_bit_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
